// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared FSM state encoding and counter width for the key debouncer.
// Revision 1.0
`default_nettype none

package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } key_state_t;

  localparam int CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one-key synchronizer, debounce FSM and optional hold counter (KEY_LONGPRESS_EN).
// Revision 1.0
`default_nettype none

module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_key,
  input  logic i_tick,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam logic [CNT_W-1:0] c_DEB = CNT_W'(DEBOUNCE_MS);

  logic [1:0]       r_sync;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_dcnt;
  logic             r_press;
  logic             r_release;
  logic             w_ks;
  logic [CNT_W-1:0] w_dcnt_inc;
  logic             w_press_acc;
  logic             w_rel_acc;

  assign w_ks        = ~r_sync[1];
  assign w_dcnt_inc  = r_dcnt + CNT_W'(1);
  assign w_press_acc = (r_state == PRESS_CHK) && w_ks && i_tick && (w_dcnt_inc == c_DEB);
  assign w_rel_acc   = (r_state == REL_CHK) && !w_ks && i_tick && (w_dcnt_inc == c_DEB);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_key};
    end
  end

  // Pin level is checked before the tick so a bounce always wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_dcnt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_press_acc;
      r_release <= w_rel_acc;
      case (r_state)
        IDLE: begin
          if (w_ks) begin
            r_state <= PRESS_CHK;
            r_dcnt  <= '0;
          end
        end
        PRESS_CHK: begin
          if (!w_ks) begin
            r_state <= IDLE;
          end else if (i_tick) begin
            r_dcnt <= w_dcnt_inc;
            if (w_press_acc) r_state <= PRESSED;
          end
        end
        PRESSED: begin
          if (!w_ks) begin
            r_state <= REL_CHK;
            r_dcnt  <= '0;
          end
        end
        REL_CHK: begin
          if (w_ks) begin
            r_state <= PRESSED;
          end else if (i_tick) begin
            r_dcnt <= w_dcnt_inc;
            if (w_rel_acc) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_level   = (r_state == PRESSED) || (r_state == REL_CHK);
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef KEY_LONGPRESS_EN
  localparam logic [CNT_W-1:0] c_LONG = CNT_W'(LONG_MS);

  logic [CNT_W-1:0] r_hcnt;
  logic             r_long;
  logic [CNT_W-1:0] w_hcnt_inc;

  assign w_hcnt_inc = r_hcnt + CNT_W'(1);

  // Hold count survives a REL_CHK bounce; only a fresh press clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hcnt <= '0;
      r_long <= 1'b0;
    end else if (w_press_acc) begin
      r_hcnt <= '0;
      r_long <= 1'b0;
    end else if (o_level && i_tick && (r_hcnt != '1)) begin
      r_hcnt <= w_hcnt_inc;
      r_long <= (w_hcnt_inc == c_LONG);
    end else begin
      r_long <= 1'b0;
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// key_debounce: N_KEYS active-low key debouncer with shared 1 ms tick and press index encoder.
// Optional long-press events when KEY_LONGPRESS_EN is defined. Revision 1.0
`default_nettype none

module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int N_KEYS      = 4
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic [N_KEYS-1:0]                            key_i,
  output logic [N_KEYS-1:0]                            key_level_o,
  output logic [N_KEYS-1:0]                            key_press_o,
  output logic [N_KEYS-1:0]                            key_release_o,
  output logic [N_KEYS-1:0]                            key_long_o,
  output logic                                         key_valid_o,
  output logic [((N_KEYS > 1) ? $clog2(N_KEYS) : 1)-1:0] key_idx_o
);

  localparam int c_P     = CLK_HZ / 1000;
  localparam int c_TW    = (c_P > 1) ? $clog2(c_P) : 1;
  localparam int c_IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  logic [c_TW-1:0]    r_tcnt;
  logic               w_tick;
  logic [c_IDX_W-1:0] w_idx;

  assign w_tick = (r_tcnt == c_TW'(c_P - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tcnt <= '0;
    end else if (w_tick) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + c_TW'(1);
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .i_key     (key_i[g]),
      .i_tick    (w_tick),
      .o_level   (key_level_o[g]),
      .o_press   (key_press_o[g]),
      .o_release (key_release_o[g]),
      .o_long    (key_long_o[g])
    );
  end

  // Scan downwards so the lowest pressed index is the last one written.
  always_comb begin
    w_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (key_press_o[i]) w_idx = c_IDX_W'(i);
    end
  end

  assign key_valid_o = |key_press_o;
  assign key_idx_o   = w_idx;

endmodule

`default_nettype wire
